hwpe_stream_source_realign_ctrl: RTL and testbench

Request-side controller that feeds `hwpe_stream_source_realign`. It turns a byte-addressed, possibly misaligned load transfer of `len_i` stream words into a sequence of word-aligned TCDM request addresses. For each request it generates the matching per-lane strobe and the `ctrl_realign_t` sideband (`realign`, `first`, `last`) that the realigner consumes. It sits between the source address/transfer logic and the TCDM load port, upstream of the realign stage.

---
 rtl/hwpe_stream_source_realign_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hwpe_stream_source_realign_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_source_realign_ctrl.sv
// Request-side controller for hwpe_stream_source_realign: word-aligned TCDM addresses, lane strobes, realign sideband.
// Optional stall counter port stall_cnt_o is enabled by defining HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN.
package hwpe_stream_realign_ctrl_pkg;
    typedef struct packed {
        logic enable;
        logic realign;
        logic first;
        logic last;
        logic last_packet;
    } ctrl_realign_t;
endpackage

module hwpe_stream_source_realign_ctrl
    import hwpe_stream_realign_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output ctrl_realign_t           ctrl_o,
    output logic                    busy_o,
`ifdef HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN
    output logic [31:0]             stall_cnt_o,
`endif
    output logic                    done_o
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   aligned_q, aligned_d;
    logic [OFFS-1:0]         off_q, off_d;
    logic                    rl_q, rl_d;
    logic [LEN_WIDTH:0]      nreq_q, nreq_d, k_q, k_d;

    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    valid_d, busy_d, done_d;
    logic [BYTES-1:0]        strb_d;
    ctrl_realign_t           ctrl_d;
    logic                    handshake, last_req;

    // Head request keeps lanes at/above the offset, tail request keeps lanes below it.
    function automatic logic [BYTES-1:0] lane_strb(input logic rl, input logic [OFFS-1:0] off,
                                                   input logic [LEN_WIDTH:0] k,
                                                   input logic [LEN_WIDTH:0] nreq);
        logic [BYTES-1:0] ones;
        ones = '1;
        if (!rl)
            return ones;
        if (k == '0)
            return ones << off;
        if (k == nreq - 1'b1)
            return ~(ones << off);
        return ones;
    endfunction

    assign handshake = addr_valid_o & addr_ready_i;
    assign last_req  = (k_q == nreq_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        aligned_d = aligned_q;
        off_d     = off_q;
        rl_d      = rl_q;
        nreq_d    = nreq_q;
        k_d       = k_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d   = REQ;
                        aligned_d = {base_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                        off_d     = base_addr_i[OFFS-1:0];
                        rl_d      = |base_addr_i[OFFS-1:0];
                        nreq_d    = {1'b0, len_i} + {{LEN_WIDTH{1'b0}}, rl_d};
                        k_d       = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (handshake) begin
                    if (last_req)
                        state_d = DONE;
                    else
                        k_d = k_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the post-edge request state.
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = (state_d == DONE);
        addr_d  = '0;
        strb_d  = '0;
        ctrl_d  = '0;
        if (state_d == REQ) begin
            valid_d        = 1'b1;
            busy_d         = 1'b1;
            addr_d         = aligned_d + (ADDR_WIDTH'(k_d) << OFFS);
            strb_d         = lane_strb(rl_d, off_d, k_d, nreq_d);
            ctrl_d.enable  = 1'b1;
            ctrl_d.realign = rl_d;
            ctrl_d.first   = (k_d == '0);
            ctrl_d.last    = (k_d == nreq_d - 1'b1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q      <= IDLE;
            addr_o       <= '0;
            addr_valid_o <= 1'b0;
            strb_o       <= '0;
            ctrl_o       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_o       <= addr_d;
            addr_valid_o <= valid_d;
            strb_o       <= strb_d;
            ctrl_o       <= ctrl_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        aligned_q <= aligned_d;
        off_q     <= off_d;
        rl_q      <= rl_d;
        nreq_q    <= nreq_d;
        k_q       <= k_d;
    end

`ifdef HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (clear_i)
            stall_cnt_q <= '0;
        else if (state_q == IDLE && start_i)
            stall_cnt_q <= '0;
        else if (addr_valid_o && !addr_ready_i && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_source_realign_ctrl.sv
// Bench for hwpe_stream_source_realign_ctrl: table vectors, corner sequences and random transfers vs. a reference model.
module tb_hwpe_stream_source_realign_ctrl;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int BY = 4;

    logic clk = 1'b0;
    logic clear_i, start_i, addr_ready_i;
    logic [AW-1:0] base_addr_i, addr_o;
    logic [LW-1:0] len_i;
    logic addr_valid_o, busy_o, done_o;
    logic [BY-1:0] strb_o;
    hwpe_stream_realign_ctrl_pkg::ctrl_realign_t ctrl_o;
`ifdef HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hwpe_stream_source_realign_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk),
        .clear_i(clear_i),
        .start_i(start_i),
        .base_addr_i(base_addr_i),
        .len_i(len_i),
        .addr_o(addr_o),
        .addr_valid_o(addr_valid_o),
        .addr_ready_i(addr_ready_i),
        .strb_o(strb_o),
        .ctrl_o(ctrl_o),
        .busy_o(busy_o),
`ifdef HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .done_o(done_o)
    );

    typedef struct {
        logic [31:0] base;
        int          len;
        int          n;
        logic [31:0] addr0;
        logic [3:0]  strb0;
        logic [3:0]  strbl;
        bit          mid_start;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: request k of a transfer, straight from the address/strobe rules.
    task automatic model(input logic [31:0] base, input int len, input int k,
                         output logic [31:0] a, output logic [3:0] s,
                         output bit f, output bit l, output bit r);
        int off;
        int n;
        off = int'(base % 32'd4);
        r = (off != 0);
        n = len + (r ? 1 : 0);
        a = (base - 32'(off)) + 32'(4 * k);
        f = (k == 0);
        l = (k == n - 1);
        for (int i = 0; i < 4; i++) begin
            if (!r)              s[i] = 1'b1;
            else if (k == 0)     s[i] = (i >= off);
            else if (k == n - 1) s[i] = (i < off);
            else                 s[i] = 1'b1;
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low for hold_cycles on request hold_k.
    task automatic run_xfer(input logic [31:0] base, input int len, input int mode,
                            input int hold_k, input int hold_cycles, input bit mid_start,
                            output int n_seen, output logic [31:0] addr0,
                            output logic [3:0] strb0, output logic [3:0] strbl);
        int n, k, cyc, stalls, held, bound;
        bit rdy, ef, el, erl;
        logic [31:0] ea;
        logic [3:0] es;
        n = (len == 0) ? 0 : len + ((base % 32'd4 != 0) ? 1 : 0);
        k = 0; cyc = 0; stalls = 0; held = 0;
        n_seen = 0; addr0 = '0; strb0 = '0; strbl = '0;
        bound = 8 * n + 40;
        base_addr_i = base;
        len_i = LW'(len);
        addr_ready_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (k < n && cyc < bound) begin
            model(base, len, k, ea, es, ef, el, erl);
            chk("valid", 64'(addr_valid_o), 64'(1));
            chk("busy", 64'(busy_o), 64'(1));
            chk("done_in_req", 64'(done_o), 64'(0));
            chk("addr", 64'(addr_o), 64'(ea));
            chk("strb", 64'(strb_o), 64'(es));
            chk("first", 64'(ctrl_o.first), 64'(ef));
            chk("last", 64'(ctrl_o.last), 64'(el));
            chk("realign", 64'(ctrl_o.realign), 64'(erl));
            chk("enable", 64'(ctrl_o.enable), 64'(1));
            chk("last_packet", 64'(ctrl_o.last_packet), 64'(0));
            if (k == 0) begin addr0 = addr_o; strb0 = strb_o; end
            if (k == n - 1) strbl = strb_o;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = !(k == hold_k && held < hold_cycles);
            endcase
            if (!rdy) begin stalls++; held++; end
            addr_ready_i = rdy;
            start_i = mid_start && cyc == 1;
            if (mid_start && cyc == 1) begin
                base_addr_i = 32'h0000_0555;
                len_i = 16'd7;
            end
            if (rdy) begin k++; n_seen++; end
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0;
        addr_ready_i = 1'b0;
        chk("complete", 64'(k), 64'(n));
        chk("done_pulse", 64'(done_o), 64'(1));
        chk("busy_at_done", 64'(busy_o), 64'(0));
        chk("valid_at_done", 64'(addr_valid_o), 64'(0));
`ifdef HWPE_STREAM_REALIGN_CTRL_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'(stalls));
`endif
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'(0));
        chk("valid_after_done", 64'(addr_valid_o), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        logic [31:0] a0;
        logic [3:0] s0, sl;

        tbl[0] = '{32'h0000_0100, 3, 3, 32'h0000_0100, 4'b1111, 4'b1111, 1'b1};
        tbl[1] = '{32'h0000_0102, 2, 3, 32'h0000_0100, 4'b1100, 4'b0011, 1'b0};
        tbl[2] = '{32'h0000_0103, 1, 2, 32'h0000_0100, 4'b1000, 4'b0111, 1'b0};
        tbl[3] = '{32'h0000_0201, 5, 6, 32'h0000_0200, 4'b1110, 4'b0001, 1'b0};
        tbl[4] = '{32'hFFFF_FFFC, 2, 2, 32'hFFFF_FFFC, 4'b1111, 4'b1111, 1'b0};
        tbl[5] = '{32'hFFFF_FFFE, 1, 2, 32'hFFFF_FFFC, 4'b1100, 4'b0011, 1'b0};

        clear_i = 1'b1; start_i = 1'b0; addr_ready_i = 1'b0;
        base_addr_i = '0; len_i = '0;
        repeat (2) @(negedge clk);
        clear_i = 1'b0;
        chk("reset_addr", 64'(addr_o), 64'(0));
        chk("reset_valid", 64'(addr_valid_o), 64'(0));
        chk("reset_strb", 64'(strb_o), 64'(0));
        chk("reset_ctrl", 64'(ctrl_o), 64'(0));
        chk("reset_busy", 64'(busy_o), 64'(0));
        chk("reset_done", 64'(done_o), 64'(0));

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].base, tbl[i].len, 0, 0, 0, tbl[i].mid_start, ns, a0, s0, sl);
            chk($sformatf("tbl%0d_nreq", i), 64'(ns), 64'(tbl[i].n));
            chk($sformatf("tbl%0d_addr0", i), 64'(a0), 64'(tbl[i].addr0));
            chk($sformatf("tbl%0d_strb0", i), 64'(s0), 64'(tbl[i].strb0));
            chk($sformatf("tbl%0d_strbl", i), 64'(sl), 64'(tbl[i].strbl));
        end

        // Backpressure on request 1 for three cycles.
        run_xfer(32'h0000_0200, 4, 2, 1, 3, 1'b0, ns, a0, s0, sl);
        chk("bp_nreq", 64'(ns), 64'(4));

        // Zero-length transfer.
        run_xfer(32'h0000_0300, 0, 0, 0, 0, 1'b0, ns, a0, s0, sl);
        chk("zero_len_nreq", 64'(ns), 64'(0));

        // Abort while request 1 is pending, then restart.
        base_addr_i = 32'h0000_0200; len_i = 16'd4; start_i = 1'b1; addr_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        addr_ready_i = 1'b1;
        @(negedge clk);
        chk("abort_req1_addr", 64'(addr_o), 64'(32'h0000_0204));
        addr_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("abort_valid", 64'(addr_valid_o), 64'(0));
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_done", 64'(done_o), 64'(0));
        chk("abort_ctrl", 64'(ctrl_o), 64'(0));
        @(negedge clk);
        chk("abort_no_late_done", 64'(done_o), 64'(0));
        run_xfer(32'h0000_0000, 1, 0, 0, 0, 1'b0, ns, a0, s0, sl);
        chk("restart_nreq", 64'(ns), 64'(1));

        for (int r = 0; r < 40; r++) begin
            logic [31:0] b;
            int l;
            b = $urandom;
            l = (r % 8 == 7) ? 0 : int'($urandom_range(1, 10));
            run_xfer(b, l, 1, 0, 0, 1'b0, ns, a0, s0, sl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
